// File: rtl/xor_arbiter_pkg.sv
// Shared constants and types for the XOR arbiter and its bench.
package xor_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Encode a one-hot grant vector into a requester index (zero if empty).
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xor_rr_pick.sv
// Round-robin picker: one-hot grant to the first valid requester after last_grant.
module xor_rr_pick
  import xor_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_grant
);

  logic [ID_W-1:0] idx;

  // Walk requesters starting one past last_grant, wrapping 3->0; first valid wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant     = '0;
    idx       = '0;
    any_grant = |req_valid;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_grant + ID_W'(k);
      if (grant == '0 && req_valid[idx]) grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/xor_arbiter.sv
// Four-requester round-robin arbiter in front of a single shared XOR unit.
// One operation is in flight at a time: IDLE grants, RESP holds the result.
module xor_arbiter
  import xor_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CNT_W-1:0]         op_count
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;
  logic               grant_en;
  logic [WIDTH-1:0]   sel_a, sel_b, xor_res;

  xor_rr_pick u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any_grant  (pick_any)
  );

  // Grants are only offered in IDLE and never while reset is held.
  assign grant_en  = rst_n && (state_q == IDLE);
  assign req_ready = grant_en ? pick_grant : '0;

  // Shared XOR unit: OR-mux the granted requester's operands (grant is one-hot).
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        sel_a = sel_a | req_a[i*WIDTH +: WIDTH];
        sel_b = sel_b | req_b[i*WIDTH +: WIDTH];
      end
    end
    xor_res = sel_a ^ sel_b;
  end

  // Next-state logic: capture on request handshake, release on response handshake.
  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant_en && pick_any) begin
          rsp_data_d   = xor_res;
          rsp_id_d     = onehot_to_idx(pick_grant);
          last_grant_d = onehot_to_idx(pick_grant);
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; last_grant=3 gives requester 0 first turn.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
    if (!rst_n) begin
      state_q      <= IDLE;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule
